// File: rtl/lsu_ctrl.sv
// RV32I load/store unit: range/alignment checks, single-cycle aligned access, byte-beat split of
// misaligned accesses when LSU_MISALIGN_EN is defined (otherwise misaligned requests fault).
`timescale 1ns/1ps
module lsu_ctrl #(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_read,
  output logic        dm_write,
  output logic [1:0]  dm_size,
  output logic        dm_sign_extend,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
`ifdef LSU_MISALIGN_EN
    SPLIT  = 2'd2,
`endif
    RESP   = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_err;
  logic [31:0] result;

  logic [1:0]  req_last;
  logic [32:0] req_end;
  logic        req_misaligned;
  logic        req_bad_code;
  logic        misalign_fault;
  logic        req_fault;
  logic        accept;

  // Request decode: N-1 from the width code, and the last byte touched computed in 33 bits
  // so that an address wrap past 2^32 also lands out of range.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
  end

  assign req_end        = {1'b0, req_addr} + {31'd0, req_last};
  assign req_misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                          (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign req_bad_code   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                          (req_funct3 == 3'b111);
`ifdef LSU_MISALIGN_EN
  assign misalign_fault = 1'b0;
`else
  assign misalign_fault = req_misaligned;
`endif
  assign req_fault = req_bad_code | (req_we & req_funct3[2]) |
                     (req_end >= 33'(MEM_SIZE)) | misalign_fault;
  assign accept    = req_valid && (state == IDLE);

`ifdef LSU_MISALIGN_EN
  logic [1:0]  beat;
  logic [1:0]  beat_last;
  logic [31:0] split_result;

  // Only H/HU and W ever split, so bit 0 of the width code picks 2 or 4 beats.
  assign beat_last = lat_f3[0] ? 2'd1 : 2'd3;

  always_comb begin
    split_result = result;
    split_result[{beat, 3'b000} +: 8] = dm_rdata[7:0];
    if (beat == beat_last && lat_f3[1:0] == 2'b01)
      split_result[31:16] = lat_f3[2] ? 16'h0000 : {16{split_result[15]}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 beat <= 2'd0;
    else if (state == SPLIT) beat <= beat + 2'd1;
    else                     beat <= 2'd0;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_fault)           state_next = RESP;
`ifdef LSU_MISALIGN_EN
          else if (req_misaligned) state_next = SPLIT;
`endif
          else                     state_next = ACCESS;
        end
      end
      ACCESS: state_next = RESP;
`ifdef LSU_MISALIGN_EN
      SPLIT:  if (beat == beat_last) state_next = RESP;
`endif
      RESP:   if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch and load result; the result is cleared on accept so stores and faults return 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_f3    <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_err   <= 1'b0;
      result    <= 32'd0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_f3    <= req_funct3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_err   <= req_fault;
        result    <= 32'd0;
      end
      if (state == ACCESS && !lat_we) result <= dm_rdata;
`ifdef LSU_MISALIGN_EN
      if (state == SPLIT && !lat_we)  result <= split_result;
`endif
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = 32'd0;
    dm_read        = 1'b0;
    dm_write       = 1'b0;
    dm_size        = 2'b00;
    dm_sign_extend = 1'b0;
    dm_addr        = 32'd0;
    dm_wdata       = 32'd0;
    case (state)
      IDLE: req_ready = ~rst;
      ACCESS: begin
        dm_read        = ~lat_we;
        dm_write       = lat_we;
        dm_size        = lat_f3[1:0];
        dm_sign_extend = ~lat_f3[2];
        dm_addr        = lat_addr;
        dm_wdata       = lat_wdata;
      end
`ifdef LSU_MISALIGN_EN
      SPLIT: begin
        dm_read  = ~lat_we;
        dm_write = lat_we;
        dm_addr  = lat_addr + {30'd0, beat};
        dm_wdata = {24'd0, lat_wdata[{beat, 3'b000} +: 8]};
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = lat_err;
        resp_rdata = result;
      end
      default: ;
    endcase
  end

endmodule
